result_display_sequencer: RTL and testbench
===========================================

# result_display_sequencer

Sequences the end-of-round presentation for the BlackJack board. It accepts a round result from the game FSM over a valid/ready handshake and blinks the result message (LOSE/WIN/TIE/BLJK) on the hex3-0 banner for a set number of periods, then holds it steady. It also latches dealer and player scores as BCD for the hex7-4 digits, and freezes them while a result is being presented. It sits between the game FSM and the output/segment driver, which only decodes `msg_code`/`msg_on` and the BCD digits into segment patterns.

## Interface
- `TICK_DIV`, 25_000_000: cycles per blink half-period (one "tick"); must be ≥2.
- `BLINK_COUNT`, 3: number of on/off blink pairs; must be ≥1.
- `HOLD_TICKS`, 4: ticks of steady display after blinking; must be ≥1.

- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `result_valid` in 1: game FSM offers a result.
- `result_code` in 2: 0 LOSE, 1 WIN, 2 TIE, 3 BLJK.
- `result_ready` out 1: sequencer can accept a result.
- `clear_msg` in 1: pulse that blanks a persisting message (new round).
- `score_update` in 1: pulse; sample `dealer_score`/`player_score`.
- `dealer_score` in 5: dealer hand total, 0-31.
- `player_score` in 5: player hand total, 0-31.
- `msg_code` out 2: latched result code for hex3-0.
- `msg_on` out 1: 1 = show message, 0 = blank hex3-0.
- `dealer_tens`, `dealer_ones`, `player_tens`, `player_ones` out 4 each: registered BCD scores.
- `busy` out 1: presentation sequence in progress.
- `done` out 1: one-cycle pulse at the end of the sequence.

## Operation
- States: IDLE, BLINK_ON, BLINK_OFF, HOLD, DONE.
- `result_ready` = (state == IDLE).
- Accept occurs when `result_valid` && `result_ready`. On accept, latch `result_code` into `msg_code`, clear the tick and blink counters, and go to BLINK_ON.
- BLINK_ON, after `TICK_DIV` cycles → BLINK_OFF.
- BLINK_OFF, after `TICK_DIV` cycles:
  - if the blink counter == `BLINK_COUNT`-1 → HOLD;
  - otherwise increment the blink counter → BLINK_ON.
- HOLD, after `HOLD_TICKS`×`TICK_DIV` cycles → DONE.
- DONE lasts one cycle → IDLE, and sets the `shown` flag.
- `msg_on` = 1 in BLINK_ON, HOLD and DONE, and in IDLE while `shown` = 1. Otherwise 0.
- `clear_msg` clears `shown` only in IDLE; it is ignored in all other states.
- If accept and `clear_msg` occur in the same cycle, accept wins and the new message sequence starts.
- `busy` = 1 in every state except IDLE. `done` = 1 only in DONE.
- Scores:
  - On `score_update` while in IDLE, register tens = score/10 and ones = score%10.
  - Tens is 0-3 (upper bits 0); ones is 0-9.
  - While `busy`, `score_update` is ignored, so the displayed scores are frozen.
- Reset values: state IDLE, `msg_code` 0, `msg_on` 0, `shown` 0, all BCD outputs 0, `busy` 0, `done` 0, counters 0.
- Reset asserted mid-sequence aborts it on the next edge, and no `done` pulse is produced.
- `result_ready` reads 0 while `reset` is high.

## Timing
- Accept at edge k → `msg_on` = 1 and `busy` = 1 from cycle k+1.
- `busy` stays high for exactly 2·`BLINK_COUNT`·`TICK_DIV` + `HOLD_TICKS`·`TICK_DIV` + 1 cycles. `done` is the last of these cycles.
- `result_ready` returns to 1 in the cycle after DONE.
- Back-to-back accept in that cycle is legal, with no dead cycle beyond DONE.
- BCD outputs update one cycle after the `score_update` edge (single register stage, no combinational path from score inputs to outputs).
- All outputs are registered.

## Configuration
- `RESULT_LEDS_EN` defined: adds outputs `greenLights` [7:0] and `redLights` [17:0], both registered and both 0 at reset.
  - WIN or BLJK: `greenLights` = 8'hFF while `msg_on`, else 0.
  - LOSE: `redLights` = 18'h3FFFF while `msg_on`, else 0.
  - TIE: `greenLights` = 8'h55 and `redLights` = 18'h15555 while `msg_on`, else 0.
- `RESULT_LEDS_EN` undefined: these ports and their logic do not exist. All other behaviour is identical.

## Test plan
Use `TICK_DIV`=4, `BLINK_COUNT`=2, `HOLD_TICKS`=3 throughout.
- Reset then idle: all outputs 0 and `result_ready`=1. `result_valid`=1, `result_code`=1 → `msg_code`=1 and `msg_on`=1 next cycle. `msg_on` pattern is 4 on / 4 off / 4 on / 4 off / 13 on. `busy` is high for 29 cycles and `done` pulses on cycle 29.
- After `done`, `msg_on` stays 1. `clear_msg` pulse → `msg_on`=0 next cycle. `clear_msg` during BLINK_OFF has no effect.
- `score_update` with dealer=17, player=21 in IDLE → next cycle `dealer_tens`=1, `dealer_ones`=7, `player_tens`=2, `player_ones`=1. A `score_update` with 30/31 during `busy` leaves the outputs unchanged.
- `result_valid` held high with code 3 across DONE → second accept in the cycle after DONE, `msg_code`=3. Simultaneous accept and `clear_msg` in IDLE → `msg_on`=1.
- `reset` asserted at cycle 10 of a sequence → next cycle state is IDLE, all outputs 0, and no `done` pulse.
- With `RESULT_LEDS_EN`:
  - code 0 → `redLights`=18'h3FFFF exactly when `msg_on`=1;
  - code 2 → `greenLights`=8'h55 and `redLights`=18'h15555 when `msg_on`=1.

Source files
------------

// File: rtl/result_display_sequencer.sv
// End-of-round result presenter: blinks the result message, holds it, then
// latches it as "shown"; optional result LEDs are enabled by RESULT_LEDS_EN.
module result_display_sequencer #(
  parameter int TICK_DIV    = 25_000_000,
  parameter int BLINK_COUNT = 3,
  parameter int HOLD_TICKS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       result_valid,
  input  logic [1:0] result_code,
  output logic       result_ready,
  input  logic       clear_msg,
  input  logic       score_update,
  input  logic [4:0] dealer_score,
  input  logic [4:0] player_score,
  output logic [1:0] msg_code,
  output logic       msg_on,
  output logic [3:0] dealer_tens,
  output logic [3:0] dealer_ones,
  output logic [3:0] player_tens,
  output logic [3:0] player_ones,
  output logic       busy,
  output logic       done
`ifdef RESULT_LEDS_EN
  ,
  output logic [7:0]  greenLights,
  output logic [17:0] redLights
`endif
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int BLINK_W = $clog2(BLINK_COUNT + 1);
  localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BLINK_ON, S_BLINK_OFF, S_HOLD, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BLINK_W-1:0]  blink_q, blink_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                shown_q, shown_d;
  logic [1:0]          msg_code_q, msg_code_d;
  logic                msg_on_q, msg_on_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          dealer_bcd_q, dealer_bcd_d;
  logic [7:0]          player_bcd_q, player_bcd_d;
  logic                accept, tick_last;

  // Score 0-31 to {tens, ones}; ones uses modulo-16 subtraction of the
  // decade base, which is exact because the remainder is always below 10.
  function automatic logic [7:0] to_bcd(input logic [4:0] s);
    logic [3:0] tens, ones;
    if (s >= 5'd30) begin
      tens = 4'd3; ones = s[3:0] - 4'd14;
    end else if (s >= 5'd20) begin
      tens = 4'd2; ones = s[3:0] - 4'd4;
    end else if (s >= 5'd10) begin
      tens = 4'd1; ones = s[3:0] - 4'd10;
    end else begin
      tens = 4'd0; ones = s[3:0];
    end
    return {tens, ones};
  endfunction

  assign result_ready = (state_q == S_IDLE) && !reset;
  assign accept       = result_valid && result_ready;
  assign tick_last    = (tick_q == TICK_W'(TICK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    blink_d    = blink_q;
    hold_d     = hold_q;
    shown_d    = shown_q;
    msg_code_d = msg_code_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          msg_code_d = result_code;
          tick_d     = '0;
          blink_d    = '0;
          hold_d     = '0;
          state_d    = S_BLINK_ON;
        end else if (clear_msg) begin
          shown_d = 1'b0;
        end
      end
      S_BLINK_ON: begin
        if (tick_last) begin
          tick_d  = '0;
          state_d = S_BLINK_OFF;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_BLINK_OFF: begin
        if (tick_last) begin
          tick_d = '0;
          if (blink_q == BLINK_W'(BLINK_COUNT - 1)) begin
            state_d = S_HOLD;
          end else begin
            blink_d = blink_q + BLINK_W'(1);
            state_d = S_BLINK_ON;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_HOLD: begin
        if (tick_last) begin
          tick_d = '0;
          if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
            state_d = S_DONE;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_DONE: begin
        shown_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with state_q.
  always_comb begin
    msg_on_d = (state_d == S_BLINK_ON) || (state_d == S_HOLD) ||
               (state_d == S_DONE) || ((state_d == S_IDLE) && shown_d);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    dealer_bcd_d = dealer_bcd_q;
    player_bcd_d = player_bcd_q;
    if (score_update && (state_q == S_IDLE)) begin
      dealer_bcd_d = to_bcd(dealer_score);
      player_bcd_d = to_bcd(player_score);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      blink_q      <= '0;
      hold_q       <= '0;
      shown_q      <= 1'b0;
      msg_code_q   <= 2'd0;
      msg_on_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dealer_bcd_q <= 8'd0;
      player_bcd_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      blink_q      <= blink_d;
      hold_q       <= hold_d;
      shown_q      <= shown_d;
      msg_code_q   <= msg_code_d;
      msg_on_q     <= msg_on_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dealer_bcd_q <= dealer_bcd_d;
      player_bcd_q <= player_bcd_d;
    end
  end

  assign msg_code    = msg_code_q;
  assign msg_on      = msg_on_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dealer_tens = dealer_bcd_q[7:4];
  assign dealer_ones = dealer_bcd_q[3:0];
  assign player_tens = player_bcd_q[7:4];
  assign player_ones = player_bcd_q[3:0];

`ifdef RESULT_LEDS_EN
  logic [7:0]  green_q, green_d;
  logic [17:0] red_q, red_d;

  always_comb begin
    green_d = 8'h00;
    red_d   = 18'h0;
    if (msg_on_d) begin
      case (msg_code_d)
        2'd0:    red_d = 18'h3FFFF;
        2'd2: begin
          green_d = 8'h55;
          red_d   = 18'h15555;
        end
        default: green_d = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      green_q <= 8'h00;
      red_q   <= 18'h0;
    end else begin
      green_q <= green_d;
      red_q   <= red_d;
    end
  end

  assign greenLights = green_q;
  assign redLights   = red_q;
`endif

endmodule

// File: tb/tb_result_display_sequencer.sv
// Scoreboard bench for result_display_sequencer: accepted codes are queued and
// matched against msg_code when done pulses; per-cycle outputs follow a model.
module tb_result_display_sequencer;
  localparam int T   = 4;
  localparam int B   = 2;
  localparam int H   = 3;
  localparam int LEN = 2 * B * T + H * T + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       result_valid = 1'b0;
  logic [1:0] result_code = 2'd0;
  logic       clear_msg = 1'b0;
  logic       score_update = 1'b0;
  logic [4:0] dealer_score = 5'd0;
  logic [4:0] player_score = 5'd0;
  logic       result_ready, msg_on, busy, done;
  logic [1:0] msg_code;
  logic [3:0] dealer_tens, dealer_ones, player_tens, player_ones;
`ifdef RESULT_LEDS_EN
  logic [7:0]  greenLights;
  logic [17:0] redLights;
`endif

  result_display_sequencer #(.TICK_DIV(T), .BLINK_COUNT(B), .HOLD_TICKS(H)) dut (
    .clk(clk), .reset(reset), .result_valid(result_valid), .result_code(result_code),
    .result_ready(result_ready), .clear_msg(clear_msg), .score_update(score_update),
    .dealer_score(dealer_score), .player_score(player_score), .msg_code(msg_code),
    .msg_on(msg_on), .dealer_tens(dealer_tens), .dealer_ones(dealer_ones),
    .player_tens(player_tens), .player_ones(player_ones), .busy(busy), .done(done)
`ifdef RESULT_LEDS_EN
    , .greenLights(greenLights), .redLights(redLights)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];
  int exp_dt = 0, exp_do = 0, exp_pt = 0, exp_po = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit exp_on(input int c);
    if (c - 1 < 2 * B * T) return (((c - 1) / T) % 2) == 0;
    return 1'b1;
  endfunction

`ifdef RESULT_LEDS_EN
  function automatic logic [7:0] exp_green(input logic [1:0] code, input bit on);
    if (!on || code == 2'd0) return 8'h00;
    return (code == 2'd2) ? 8'h55 : 8'hFF;
  endfunction
  function automatic logic [17:0] exp_red(input logic [1:0] code, input bit on);
    if (!on) return 18'h0;
    if (code == 2'd0) return 18'h3FFFF;
    return (code == 2'd2) ? 18'h15555 : 18'h0;
  endfunction
`endif

  task automatic chk_digits(input string tag);
    chk({tag, "_dt"}, dealer_tens, exp_dt);
    chk({tag, "_do"}, dealer_ones, exp_do);
    chk({tag, "_pt"}, player_tens, exp_pt);
    chk({tag, "_po"}, player_ones, exp_po);
  endtask

  task automatic idle_chk(input string tag, input bit exp_msg, input logic [1:0] exp_code);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ready"}, result_ready, 1);
    chk({tag, "_msg_on"}, msg_on, exp_msg);
    chk({tag, "_msg_code"}, msg_code, exp_code);
    chk_digits(tag);
`ifdef RESULT_LEDS_EN
    chk({tag, "_green"}, greenLights, exp_green(exp_code, exp_msg));
    chk({tag, "_red"}, redLights, exp_red(exp_code, exp_msg));
`endif
  endtask

  // Entered on cycle 1 of a sequence; returns on its DONE cycle or after an abort.
  task automatic run_seq(input logic [1:0] code, input int clear_c, input int score_c,
                         input int abort_c, input bit keep_valid);
    bit on;
    result_valid = keep_valid;
    for (int c = 1; c <= LEN; c++) begin
      on = exp_on(c);
      chk("seq_busy", busy, 1);
      chk("seq_msg_on", msg_on, on);
      chk("seq_done", done, (c == LEN));
      chk("seq_ready", result_ready, 0);
      chk("seq_msg_code", msg_code, code);
      chk_digits("seq");
`ifdef RESULT_LEDS_EN
      chk("seq_green", greenLights, exp_green(code, on));
      chk("seq_red", redLights, exp_red(code, on));
`endif
      if (done) begin
        chk("sb_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("sb_code", msg_code, exp_q.pop_front());
      end
      if (c == abort_c) begin
        reset = 1'b1;
        step();
        exp_q.delete();
        exp_dt = 0; exp_do = 0; exp_pt = 0; exp_po = 0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_msg_on", msg_on, 0);
        chk("abort_msg_code", msg_code, 0);
        chk("abort_ready", result_ready, 0);
        chk_digits("abort");
        reset = 1'b0;
        return;
      end
      if (c == LEN) break;
      clear_msg = (c == clear_c);
      score_update = (c == score_c);
      if (c == score_c) begin
        dealer_score = 5'd30;
        player_score = 5'd31;
      end
      step();
      clear_msg = 1'b0;
      score_update = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk("rst_ready", result_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_msg_on", msg_on, 0);
    reset = 1'b0;
    #1;
    idle_chk("reset_idle", 0, 2'd0);

    dealer_score = 5'd17; player_score = 5'd21; score_update = 1'b1;
    step();
    score_update = 1'b0;
    exp_dt = 1; exp_do = 7; exp_pt = 2; exp_po = 1;
    chk_digits("score");

    result_code = 2'd1; result_valid = 1'b1; exp_q.push_back(2'd1);
    step();
    run_seq(2'd1, 6, 3, 0, 1'b0);
    step();
    idle_chk("after_done", 1, 2'd1);
    repeat (3) step();
    idle_chk("persist", 1, 2'd1);
    clear_msg = 1'b1;
    step();
    clear_msg = 1'b0;
    idle_chk("cleared", 0, 2'd1);

    result_code = 2'd3; result_valid = 1'b1; exp_q.push_back(2'd3);
    step();
    run_seq(2'd3, 0, 0, 0, 1'b1);
    exp_q.push_back(2'd3);
    step();
    idle_chk("b2b_gap", 1, 2'd3);
    step();
    run_seq(2'd3, 0, 0, 0, 1'b0);
    step();
    idle_chk("b2b_end", 1, 2'd3);

    result_code = 2'd2; clear_msg = 1'b1; result_valid = 1'b1; exp_q.push_back(2'd2);
    step();
    clear_msg = 1'b0;
    run_seq(2'd2, 0, 0, 10, 1'b0);
    for (int i = 0; i < LEN + 2; i++) begin
      step();
      idle_chk("post_abort", 0, 2'd0);
    end

`ifdef RESULT_LEDS_EN
    result_code = 2'd0; result_valid = 1'b1; exp_q.push_back(2'd0);
    step();
    run_seq(2'd0, 0, 0, 0, 1'b0);
    step();
    idle_chk("led_lose", 1, 2'd0);
    result_code = 2'd2; result_valid = 1'b1; exp_q.push_back(2'd2);
    step();
    run_seq(2'd2, 0, 0, 0, 1'b0);
    step();
    idle_chk("led_tie", 1, 2'd2);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
